// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the 4x4 multiplier controller: present-state
// encodings and the 3-bit state type used by the sequencer, the output
// decoder and the bench.
package mult_ctrl_pkg;

    localparam logic [2:0] PS_IDLE    = 3'b000;
    localparam logic [2:0] PS_CLR     = 3'b001;
    localparam logic [2:0] PS_LD1     = 3'b010;
    localparam logic [2:0] PS_LD2     = 3'b011;
    localparam logic [2:0] PS_ADD     = 3'b100;
    localparam logic [2:0] PS_SHF     = 3'b101;
    localparam logic [2:0] PS_ACC     = 3'b110;
    localparam logic [2:0] PS_ILLEGAL = 3'b111;

    typedef enum logic [2:0] {
        IDLE    = PS_IDLE,
        CLR     = PS_CLR,
        LD1     = PS_LD1,
        LD2     = PS_LD2,
        ADD     = PS_ADD,
        SHF     = PS_SHF,
        ACC     = PS_ACC,
        ILLEGAL = PS_ILLEGAL
    } state_t;

endpackage

// File: rtl/mult_sequencer_iter_counter.sv
// Loop iteration counter for the multiplier sequencer. Clear has priority
// over increment; last flags the final iteration (N_ITER-1).
module iter_counter #(
    parameter int N_ITER = 4,
    parameter int CNT_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    // Iteration count register; cleared on operation entry/exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(N_ITER - 1));

endmodule

// File: rtl/mult_sequencer.sv
// State register and next-state logic for the 4x4 multiplier controller.
// Sequences CLR, LD1, LD2 and then N_ITER rounds of ADD/SHF/ACC, with a
// start/busy/done handshake, synchronous abort and illegal-state recovery.
// Optional: define MULT_SEQ_STALL_EN to add a stall input that freezes
// the sequence (except in IDLE).
module mult_sequencer
    import mult_ctrl_pkg::*;
#(
    parameter int N_ITER = 4,
    parameter int CNT_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
`ifdef MULT_SEQ_STALL_EN
    input  logic             stall,
`endif
    output logic [2:0]       ps,
    output logic [CNT_W-1:0] iter,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t state_q;
    state_t state_d;
    logic   cnt_clr;
    logic   cnt_inc;
    logic   cnt_last;
    logic   done_d;
    logic   err_d;

    iter_counter #(
        .N_ITER (N_ITER),
        .CNT_W  (CNT_W)
    ) u_iter_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (iter),
        .last  (cnt_last)
    );

    // Next-state, counter control and pulse generation
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = CLR;
                    cnt_clr = 1'b1;
                end
            end
            CLR: state_d = LD1;
            LD1: state_d = LD2;
            LD2: state_d = ADD;
            ADD: state_d = SHF;
            SHF: state_d = ACC;
            ACC: begin
                if (cnt_last) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    state_d = ADD;
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                // 3'b111 is unreachable in normal operation; recover to IDLE
                state_d = IDLE;
                cnt_clr = 1'b1;
                err_d   = 1'b1;
            end
        endcase
`ifdef MULT_SEQ_STALL_EN
        // Stall freezes everything outside IDLE; abort still wins below
        if (stall && (state_q != IDLE)) begin
            state_d = state_q;
            cnt_clr = 1'b0;
            cnt_inc = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
`endif
        // Abort abandons any operation in progress without a done pulse
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
            cnt_inc = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    assign ps   = state_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer (N_ITER=4): expected per-cycle outputs are queued
// when stimulus is applied and compared as the sequencer advances.
module tb_mult_sequencer;
    import mult_ctrl_pkg::*;

    localparam int N_ITER = 4;
    localparam int CNT_W  = 3;

    typedef struct packed {
        logic [2:0]       ps;
        logic [CNT_W-1:0] iter;
        logic             busy;
        logic             done;
        logic             err;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             stall = 1'b0;
    logic [2:0]       ps;
    logic [CNT_W-1:0] iter;
    logic             busy;
    logic             done;
    logic             err;

    int checks = 0;
    int failures = 0;
    obs_t exp_q[$];

    mult_sequencer #(.N_ITER(N_ITER), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
`ifdef MULT_SEQ_STALL_EN
        .stall (stall),
`endif
        .ps    (ps),
        .iter  (iter),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(logic [2:0] p, int it, logic dn, logic er);
        obs_t o;
        o.ps   = p;
        o.iter = CNT_W'(it);
        o.busy = (p != 3'b000);
        o.done = dn;
        o.err  = er;
        return o;
    endfunction

    // Expected value for cycle k (1..16) of an operation started in cycle 0
    function automatic obs_t op_entry(int k);
        int j;
        if (k == 1) return mk(3'b001, 0, 1'b0, 1'b0);
        if (k == 2) return mk(3'b010, 0, 1'b0, 1'b0);
        if (k == 3) return mk(3'b011, 0, 1'b0, 1'b0);
        if (k == 4 + 3 * N_ITER) return mk(3'b000, 0, 1'b1, 1'b0);
        j = k - 4;
        case (j % 3)
            0:       return mk(3'b100, j / 3, 1'b0, 1'b0);
            1:       return mk(3'b101, j / 3, 1'b0, 1'b0);
            default: return mk(3'b110, j / 3, 1'b0, 1'b0);
        endcase
    endfunction

    task automatic push_op(input int from, input int upto);
        for (int k = from; k <= upto; k++) exp_q.push_back(op_entry(k));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t now_obs();
        obs_t o;
        o.ps = ps; o.iter = iter; o.busy = busy; o.done = done; o.err = err;
        return o;
    endfunction

    task automatic test_reset();
        obs_t got, e;
        #3 rst_n = 1'b0;
        #1;
        got = now_obs();
        e = mk(3'b000, 0, 1'b0, 1'b0);
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_async got=%h expected=%h", got, e);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        got = now_obs();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_idle got=%h expected=%h", got, e);
        end
    endtask

    task automatic test_single_op();
        obs_t got, e;
        start = 1'b1;
        push_op(1, 16);
        exp_q.push_back(mk(3'b000, 0, 1'b0, 1'b0));
        for (int c = 1; c <= 17; c++) begin
            step();
            start = 1'b0;
            got = now_obs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL single_op cycle=%0d got=%h expected=%h", c, got, e);
            end
        end
    endtask

    task automatic test_abort();
        obs_t got, e;
        start = 1'b1;
        push_op(1, 11);
        exp_q.push_back(mk(3'b000, 0, 1'b0, 1'b0));
        exp_q.push_back(mk(3'b000, 0, 1'b0, 1'b0));
        for (int c = 1; c <= 13; c++) begin
            step();
            start = 1'b0;
            abort = (c == 11);
            got = now_obs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL abort cycle=%0d got=%h expected=%h", c, got, e);
            end
        end
        abort = 1'b0;
    endtask

    task automatic test_start_abort_idle();
        obs_t got, e;
        start = 1'b1;
        abort = 1'b1;
        repeat (3) exp_q.push_back(mk(3'b000, 0, 1'b0, 1'b0));
        for (int c = 1; c <= 3; c++) begin
            step();
            got = now_obs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL start_abort_idle cycle=%0d got=%h expected=%h", c, got, e);
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_back_to_back();
        obs_t got, e;
        start = 1'b1;
        push_op(1, 16);
        push_op(1, 16);
        exp_q.push_back(mk(3'b000, 0, 1'b0, 1'b0));
        for (int c = 1; c <= 33; c++) begin
            step();
            if (c == 31) start = 1'b0;
            got = now_obs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL back_to_back cycle=%0d got=%h expected=%h", c, got, e);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_illegal();
        obs_t got, e;
        @(negedge clk);
        force dut.state_q = ILLEGAL;
        #1 release dut.state_q;
        exp_q.push_back(mk(3'b000, 0, 1'b0, 1'b1));
        exp_q.push_back(mk(3'b000, 0, 1'b0, 1'b0));
        for (int c = 1; c <= 2; c++) begin
            step();
            got = now_obs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL illegal_recover cycle=%0d got=%h expected=%h", c, got, e);
            end
        end
        start = 1'b1;
        push_op(1, 16);
        for (int c = 1; c <= 16; c++) begin
            step();
            start = 1'b0;
            got = now_obs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL illegal_then_op cycle=%0d got=%h expected=%h", c, got, e);
            end
        end
    endtask

`ifdef MULT_SEQ_STALL_EN
    task automatic test_stall();
        obs_t got, e;
        start = 1'b1;
        push_op(1, 7);
        repeat (3) exp_q.push_back(op_entry(7));
        push_op(8, 16);
        for (int c = 1; c <= 19; c++) begin
            step();
            start = 1'b0;
            if (c == 7)  stall = 1'b1;
            if (c == 10) stall = 1'b0;
            got = now_obs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL stall cycle=%0d got=%h expected=%h", c, got, e);
            end
        end
        stall = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        obs_t got, e;
        start = 1'b1;
        push_op(1, 6);
        for (int c = 1; c <= 6; c++) begin
            step();
            start = 1'b0;
            got = now_obs();
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reset_mid_pre cycle=%0d got=%h expected=%h", c, got, e);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        got = now_obs();
        e = mk(3'b000, 0, 1'b0, 1'b0);
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL reset_mid_async got=%h expected=%h", got, e);
        end
        step();
        @(negedge clk) rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            got = now_obs();
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL reset_mid_after cycle=%0d got=%h expected=%h", c, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_abort();
        test_start_abort_idle();
        test_back_to_back();
        test_illegal();
`ifdef MULT_SEQ_STALL_EN
        test_stall();
`endif
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
